inv_sub_bytes_seq: RTL and testbench
====================================

Name: inv_sub_bytes_seq

Overview:
- Iterative AES InvSubBytes stage for the decryption datapath. It is the inverse of the forward SubBytes stage.
- Accepts a 128-bit state on a start strobe and substitutes LANES bytes per cycle through LANES shared inverse S-box ROMs.
- Registers the full 128-bit result and pulses done.
- Trades latency for area against the fully parallel forward block, and gates S-box inputs when idle for low power.

Parameters:
- LANES, 4, number of bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16. NGROUPS = 16/LANES.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to process blocoIn. Sampled only in IDLE.
- blocoIn  input  [0:127]  ciphertext-side state. Byte k = blocoIn[8k:8k+7], MSB-first; byte 0 = bits [0:7].
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse: blocoOut holds a new result.
- blocoOut  output  [0:127]  InvSubBytes result, same byte ordering as blocoIn.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clock.
  - Values forced by reset: state=IDLE, group counter=0, capture register=0, blocoOut=0, busy=0, done=0.
  - Reset asserted mid-operation aborts the block. No done pulse follows, and blocoOut returns to 0.
- FSM with two states: IDLE and RUN.
  - IDLE, start=1: capture blocoIn into the internal register, counter←0, busy←1, go to RUN.
  - IDLE, start=0: remain in IDLE.
  - RUN, each cycle: bytes [counter*LANES .. counter*LANES+LANES-1] of the captured state pass through the inverse S-box. Results are written into the same positions of a working result register, and counter increments.
  - RUN, last group (counter = NGROUPS-1): transfer the completed result, including the final group, into blocoOut. At the same edge assert done for exactly one cycle, clear busy, counter←0, go to IDLE.
- Latency: start is sampled at edge E0 and done/blocoOut update at edge E0+NGROUPS.
  - LANES=4: 4 cycles.
  - LANES=16: 1 cycle.
  - LANES=1: 16 cycles.
- Throughput: the FSM is in IDLE during the done cycle, so start asserted in that cycle is accepted. Back-to-back blocks therefore run every NGROUPS+1 cycles.
- start while busy=1 is ignored, not queued. blocoIn changes while busy have no effect on the result, because the data was captured at acceptance.
- blocoOut holds its last value between done pulses. It is never partially updated; intermediate groups live only in the working register.
- Operand isolation: S-box address inputs are ANDed to 0x00 whenever state≠RUN, so lookup logic does not toggle while idle.
- Inverse S-box: the 256-entry FIPS-197 inverse table, combinational ROM, indexed by the byte value (high nibble = row, low nibble = column).
- Counter width: ceil(log2(NGROUPS)), minimum 1 bit. It wraps to 0 only via the last-group transition.
- busy and done are never both high in the same cycle.

Test Plan:
- Reset, then idle 5 cycles with blocoIn toggling -> blocoOut=0, busy=0, done=0 throughout, and S-box address inputs held at 0x00.
- LANES=4, blocoIn=d42711aee0bf98f1b8b45de51e415230, start=1 for one cycle -> busy high 4 cycles, then done pulses one cycle with blocoOut=193de3bea0f4e22b9ac68d2ae9f84808.
- Per-byte table spot checks, issued as separate blocks:
  - blocoIn with all bytes 0x63 -> all 0x00.
  - all 0x00 -> all 0x52.
  - all 0x16 -> all 0xFF.
  - byte0=0x7C, byte15=0xED, others 0x63 -> byte0=0x01, byte15=0x53, others 0x00.
- Handshake corners:
  - start held high continuously -> a new block is accepted in every done cycle, giving a done period of 5 cycles.
  - start pulsed while busy -> ignored.
  - blocoIn changed mid-RUN -> result reflects the captured value only.
- Reset asserted at the 2nd RUN cycle -> no done, blocoOut=0, busy=0 next cycle. A following start completes normally.
- Parameter sweep LANES∈{1,16}: 256 random blocks, each checked by passing through the forward SubBytes block and then this block. Result must equal the original input, and latency must be 16 and 1 respectively.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes LANES bytes per cycle through shared inverse S-box ROMs
// and publishes the full 128-bit result with a one-cycle done pulse.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] blocoIn,
    output logic         busy,
    output logic         done,
    output logic [0:127] blocoOut
);

    localparam int NGROUPS = 16 / LANES;
    localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NGROUPS - 1);

    // FIPS-197 inverse S-box, one row per high nibble; entry 0x00 sits at bits [0:7].
    localparam logic [0:2047] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                accept;
    logic                last_grp;
    logic [0:127]        cap_q;
    logic [0:127]        work_q;
    logic [0:127]        merged;
    logic [LANES*8-1:0]  sbox_in;
    logic [LANES*8-1:0]  sbox_out;

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return INV_TAB[{a, 3'b000} +: 8];
    endfunction

    // Handshake: start is a request honoured only in IDLE (busy=0); once taken, busy stays high
    // until the result lands, then done pulses for one cycle with busy already low. Requests
    // made while busy are dropped, and blocoIn is only sampled on the accepting edge.
    assign accept   = (state == IDLE) && start;
    assign last_grp = (cnt == LAST_GRP);

    // Lane datapath; the AND with the RUN flag keeps the ROM address at 0x00 while idle.
    always_comb begin
        sbox_in  = '0;
        sbox_out = '0;
        merged   = work_q;
        for (int l = 0; l < LANES; l++) begin
            sbox_in[l*8 +: 8]  = cap_q[(int'(cnt) * LANES + l) * 8 +: 8] & {8{state == RUN}};
            sbox_out[l*8 +: 8] = inv_sbox(sbox_in[l*8 +: 8]);
            merged[(int'(cnt) * LANES + l) * 8 +: 8] = sbox_out[l*8 +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (last_grp) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cap_q    <= '0;
            work_q   <= '0;
            blocoOut <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (accept) begin
                cap_q <= blocoIn;
            end
            if (state == RUN) begin
                work_q <= merged;
            end
            // merged already carries the final group, so blocoOut is only ever written whole.
            if (done_nxt) begin
                blocoOut <= merged;
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: known-answer, table spots, handshake corners, reset abort and
// a forward-SubBytes round-trip sweep on LANES = 1 and 16.
module tb_inv_sub_bytes_seq;

    localparam logic [0:2047] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start4 = 1'b0, start1 = 1'b0, start16 = 1'b0;
    logic [0:127] bin4 = '0, bin1 = '0, bin16 = '0;
    logic         busy4, busy1, busy16;
    logic         done4, done1, done16;
    logic [0:127] bout4, bout1, bout16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];

    inv_sub_bytes_seq #(.LANES(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .blocoIn(bin4),
        .busy(busy4), .done(done4), .blocoOut(bout4)
    );
    inv_sub_bytes_seq #(.LANES(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .blocoIn(bin1),
        .busy(busy1), .done(done1), .blocoOut(bout1)
    );
    inv_sub_bytes_seq #(.LANES(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .blocoIn(bin16),
        .busy(busy16), .done(done16), .blocoOut(bout16)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // stimulus model and driver tasks
    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [0:2047] t;
        t = FWD_TAB;
        return t[{a, 3'b000} +: 8];
    endfunction

    function automatic logic [0:127] fwd_block(input logic [0:127] d);
        logic [0:127] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[k*8 +: 8] = fwd_sbox(d[k*8 +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_in(input int which, input logic s, input logic [0:127] d);
        case (which)
            1:       begin start1 = s;  bin1 = d;  end
            16:      begin start16 = s; bin16 = d; end
            default: begin start4 = s;  bin4 = d;  end
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            1:       return done1;
            16:      return done16;
            default: return done4;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            1:       return busy1;
            16:      return busy16;
            default: return busy4;
        endcase
    endfunction

    function automatic logic [0:127] get_out(input int which);
        case (which)
            1:       return bout1;
            16:      return bout16;
            default: return bout4;
        endcase
    endfunction

    // One-cycle start pulse, then wait (bounded) for done; lat counts edges after acceptance.
    task automatic run_block(input int which, input logic [0:127] din,
                             output int lat, output int busy_cnt, output bit ok);
        set_in(which, 1'b1, din);
        tick;
        set_in(which, 1'b0, din);
        lat = 0;
        busy_cnt = 0;
        ok = 1'b0;
        while (lat < 64 && !ok) begin
            if (get_busy(which)) busy_cnt++;
            tick;
            lat++;
            if (get_done(which)) ok = 1'b1;
        end
    endtask

    task automatic wait_done4(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            tick;
            n++;
            if (done4) ok = 1'b1;
        end
    endtask

    // tests
    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (bout4 !== '0) begin errors++; $display("FAIL reset_out got %h want 0", bout4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
        checks++; if (bout1 !== '0 || bout16 !== '0) begin
            errors++; $display("FAIL reset_out_sweep got %h %h want 0", bout1, bout16);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bin4 = rand128();
            tick;
            checks++; if (bout4 !== '0) begin errors++; $display("FAIL idle_out got %h want 0", bout4); end
            checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy4); end
            checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done4); end
            checks++; if (dut4.sbox_in !== '0) begin
                errors++; $display("FAIL idle_sbox_addr got %h want 0", dut4.sbox_in);
            end
        end
    endtask

    task automatic test_known_answer;
        int lat, bc;
        bit ok;
        logic [127:0] e;
        exp_q.push_back(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        run_block(4, 128'hd42711aee0bf98f1b8b45de51e415230, lat, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL kat_timeout got no done want done"); end
        e = exp_q.pop_front();
        checks++; if (bout4 !== e) begin errors++; $display("FAIL kat_data got %h want %h", bout4, e); end
        checks++; if (lat != 4) begin errors++; $display("FAIL kat_latency got %0d want 4", lat); end
        checks++; if (bc != 4) begin errors++; $display("FAIL kat_busy_cycles got %0d want 4", bc); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL kat_busy_at_done got %b want 0", busy4); end
        tick;
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL kat_done_width got %b want 0", done4); end
        checks++; if (bout4 !== e) begin errors++; $display("FAIL kat_hold got %h want %h", bout4, e); end
    endtask

    task automatic test_table_spots;
        logic [127:0] ins[4];
        logic [127:0] outs[4];
        logic [127:0] e;
        int lat, bc;
        bit ok;
        ins[0] = {16{8'h63}};                outs[0] = '0;
        ins[1] = '0;                          outs[1] = {16{8'h52}};
        ins[2] = {16{8'h16}};                outs[2] = {16{8'hff}};
        ins[3] = {8'h7c, {14{8'h63}}, 8'hed}; outs[3] = {8'h01, {14{8'h00}}, 8'h53};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(outs[i]);
            run_block(4, ins[i], lat, bc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL spot%0d_timeout got no done want done", i); end
            e = exp_q.pop_front();
            checks++; if (bout4 !== e) begin errors++; $display("FAIL spot%0d_data got %h want %h", i, bout4, e); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [0:127] r[4];
        logic [127:0] e;
        int n, last_done;
        bit ok;
        for (int i = 0; i < 4; i++) r[i] = rand128();
        bin4 = fwd_block(r[0]);
        exp_q.push_back(r[0]);
        start4 = 1'b1;
        tick;
        last_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bin4 = fwd_block(r[i+1]);
                exp_q.push_back(r[i+1]);
            end
            wait_done4(n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout blk %0d got no done want done", i); end
            checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_busy_done_overlap got %b want 0", busy4); end
            e = exp_q.pop_front();
            checks++; if (bout4 !== e) begin errors++; $display("FAIL b2b_data blk %0d got %h want %h", i, bout4, e); end
            if (i > 0) begin
                checks++; if (cyc - last_done != 5) begin
                    errors++; $display("FAIL b2b_period got %0d want 5", cyc - last_done);
                end
            end
            last_done = cyc;
            tick;
            if (i == 2) start4 = 1'b0;
        end
    endtask

    task automatic test_start_while_busy;
        logic [0:127] rx, ry;
        logic [127:0] e;
        int n, extra;
        bit ok;
        rx = rand128();
        ry = rand128();
        exp_q.push_back(rx);
        bin4 = fwd_block(rx);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        start4 = 1'b1;
        bin4 = fwd_block(ry);
        tick;
        start4 = 1'b0;
        wait_done4(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout got no done want done"); end
        e = exp_q.pop_front();
        checks++; if (bout4 !== e) begin errors++; $display("FAIL busy_start_data got %h want %h", bout4, e); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done4 === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_start_queued got %0d dones want 0", extra); end
    endtask

    task automatic test_reset_mid_run;
        logic [0:127] r;
        logic [127:0] e;
        int lat, bc, extra;
        bit ok;
        bin4 = fwd_block(rand128());
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (bout4 !== '0) begin errors++; $display("FAIL abort_out got %h want 0", bout4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done4); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done4 === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL abort_late_done got %0d want 0", extra); end
        r = rand128();
        exp_q.push_back(r);
        run_block(4, fwd_block(r), lat, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL after_abort_timeout got no done want done"); end
        e = exp_q.pop_front();
        checks++; if (bout4 !== e) begin errors++; $display("FAIL after_abort_data got %h want %h", bout4, e); end
        checks++; if (lat != 4) begin errors++; $display("FAIL after_abort_latency got %0d want 4", lat); end
    endtask

    task automatic test_sweep(input int which);
        logic [0:127] r;
        logic [127:0] e;
        int lat, bc, exp_lat;
        bit ok;
        exp_lat = 16 / which;
        for (int i = 0; i < 256; i++) begin
            r = rand128();
            exp_q.push_back(r);
            run_block(which, fwd_block(r), lat, bc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL sweep%0d_timeout blk %0d got no done want done", which, i); end
            e = exp_q.pop_front();
            checks++; if (get_out(which) !== e) begin
                errors++; $display("FAIL sweep%0d_data blk %0d got %h want %h", which, i, get_out(which), e);
            end
            checks++; if (lat != exp_lat) begin
                errors++; $display("FAIL sweep%0d_latency got %0d want %0d", which, lat, exp_lat);
            end
        end
    endtask

    // sequence and final report
    initial begin
        test_reset;
        test_known_answer;
        test_table_spots;
        test_back_to_back;
        test_start_while_busy;
        test_reset_mid_run;
        test_sweep(1);
        test_sweep(16);
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
